// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Width of the memory-latency counter; covers MEM_LAT up to 15.
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    // One-hot grant vector for a port id (bit 0 = core, bit 1 = debug).
    function automatic logic [1:0] id_to_onehot(input port_id_t id);
        logic [1:0] oh;
        if (id == PORT_D) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// port that did not win last time is chosen.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last,
    output logic [1:0] gnt,
    output port_id_t   winner
);

    // Pick the winner and build its one-hot grant.
    always_comb begin
        winner = PORT_C;
        gnt    = 2'b00;
        case (req)
            2'b01:   winner = PORT_C;
            2'b10:   winner = PORT_D;
            2'b11:   winner = (last == PORT_C) ? PORT_D : PORT_C;
            default: winner = PORT_C;
        endcase
        if (req != 2'b00) begin
            gnt = id_to_onehot(winner);
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (C) and the
// debug/loader port (D). One access at a time: grant, issue, wait out the
// memory latency, respond.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                c_req,
    input  logic                c_we,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_be,
    output logic                c_gnt,
    output logic                c_rvalid,
    output logic [DATA_W-1:0]   c_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    state_t           state;
    port_id_t         last_gnt;
    port_id_t         cur_id;
    port_id_t         winner;
    logic             cur_we;
    logic [LAT_W-1:0] lat_cnt;
    logic [1:0]       req_vec;
    logic [1:0]       arb_gnt;
    logic             grant_ok;

    assign req_vec = {d_req, c_req};

    rr_arb2 u_arb (
        .req    (req_vec),
        .last   (last_gnt),
        .gnt    (arb_gnt),
        .winner (winner)
    );

    // Grants are only offered while idle; reset suppresses them immediately.
    assign grant_ok = (state == IDLE) && !reset;
    assign c_gnt    = grant_ok & arb_gnt[0];
    assign d_gnt    = grant_ok & arb_gnt[1];

    // Access sequencer: latches the winner's request, drives the memory for
    // one cycle, counts out the read latency, then pulses the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last_gnt  <= PORT_D;
            cur_id    <= PORT_C;
            cur_we    <= 1'b0;
            lat_cnt   <= '0;
            c_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            c_rdata   <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            // Pulses and memory strobes default low; overridden below.
            c_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            case (state)
                IDLE: begin
                    if (req_vec != 2'b00) begin
                        state    <= ISSUE;
                        last_gnt <= winner;
                        cur_id   <= winner;
                        mem_en   <= 1'b1;
                        if (winner == PORT_D) begin
                            cur_we    <= d_we;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                        end else begin
                            cur_we    <= c_we;
                            mem_we    <= c_we;
                            mem_addr  <= c_addr;
                            mem_wdata <= c_wdata;
                            mem_be    <= c_be;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_W'(1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == LAT_W'(MEM_LAT)) begin
                        state   <= RESP;
                        lat_cnt <= '0;
                        if (cur_id == PORT_D) begin
                            d_rvalid <= 1'b1;
                            if (!cur_we) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                d_rdata <= d_rdata;
                            end
                        end else begin
                            c_rvalid <= 1'b1;
                            if (!cur_we) begin
                                c_rdata <= mem_rdata;
                            end else begin
                                c_rdata <= c_rdata;
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte-enable width is fixed by the data width.
    if (BE_W < 1) begin : g_bad_width
        $error("DATA_W must be at least 8");
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with MEM_LAT=1 (outputs a_*)
// and one with MEM_LAT=3 (outputs b_*) share the same stimulus.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;
    logic [3:0]  c_be, d_be;

    logic        a_c_gnt, a_c_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we;
    logic [31:0] a_c_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_be;
    logic        b_c_gnt, b_c_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we;
    logic [31:0] b_c_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_be;

    int vectors;
    int miscompares;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_gnt(a_c_gnt), .c_rvalid(a_c_rvalid), .c_rdata(a_c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_gnt(b_c_gnt), .c_rvalid(b_c_rvalid), .c_rdata(b_c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_be = 4'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        mem_rdata = 32'h0;
        c_req = 1'b1; d_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (a_c_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_c_gnt: got %b want 0", a_c_gnt); end
        vectors++; if (a_d_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_d_gnt: got %b want 0", a_d_gnt); end
        vectors++; if (a_mem_en !== 1'b0) begin miscompares++; $display("FAIL rst_mem_en: got %b want 0", a_mem_en); end
        vectors++; if (a_c_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_c_rvalid: got %b want 0", a_c_rvalid); end
        vectors++; if (a_d_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_d_rvalid: got %b want 0", a_d_rvalid); end
        vectors++; if (a_c_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_c_rdata: got %h want 0", a_c_rdata); end
        vectors++; if (a_d_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_d_rdata: got %h want 0", a_d_rdata); end
        vectors++; if (a_mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr: got %h want 0", a_mem_addr); end
    endtask

    // Both ports held from reset: grants alternate C, D, C, D every 4 cycles.
    task automatic test_alternate();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            vectors++; if (a_c_gnt !== ((i % 8) == 0)) begin miscompares++; $display("FAIL alt_c_gnt[%0d]: got %b want %b", i, a_c_gnt, (i % 8) == 0); end
            vectors++; if (a_d_gnt !== ((i % 8) == 4)) begin miscompares++; $display("FAIL alt_d_gnt[%0d]: got %b want %b", i, a_d_gnt, (i % 8) == 4); end
            vectors++; if (a_mem_en !== ((i % 4) == 1)) begin miscompares++; $display("FAIL alt_mem_en[%0d]: got %b want %b", i, a_mem_en, (i % 4) == 1); end
            vectors++; if (a_c_rvalid !== ((i % 8) == 3)) begin miscompares++; $display("FAIL alt_c_rvalid[%0d]: got %b want %b", i, a_c_rvalid, (i % 8) == 3); end
            vectors++; if (a_d_rvalid !== ((i % 8) == 7)) begin miscompares++; $display("FAIL alt_d_rvalid[%0d]: got %b want %b", i, a_d_rvalid, (i % 8) == 7); end
        end
        @(negedge clk);
        clear_inputs();
        repeat (10) @(negedge clk);
    endtask

    // Core read, MEM_LAT=1: gnt T, mem_en T+1, rvalid T+3.
    task automatic test_read_lat1();
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0010; mem_rdata = 32'hDEAD_BEEF;
        #1;
        vectors++; if (a_c_gnt !== 1'b1) begin miscompares++; $display("FAIL rd1_c_gnt: got %b want 1", a_c_gnt); end
        vectors++; if (a_d_gnt !== 1'b0) begin miscompares++; $display("FAIL rd1_d_gnt: got %b want 0", a_d_gnt); end
        @(negedge clk);
        c_req = 1'b0;
        vectors++; if (a_mem_en !== 1'b1) begin miscompares++; $display("FAIL rd1_mem_en: got %b want 1", a_mem_en); end
        vectors++; if (a_mem_we !== 1'b0) begin miscompares++; $display("FAIL rd1_mem_we: got %b want 0", a_mem_we); end
        vectors++; if (a_mem_addr !== 32'h0000_0010) begin miscompares++; $display("FAIL rd1_mem_addr: got %h want 00000010", a_mem_addr); end
        @(negedge clk);
        vectors++; if (a_mem_en !== 1'b0) begin miscompares++; $display("FAIL rd1_mem_en_off: got %b want 0", a_mem_en); end
        vectors++; if (a_c_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd1_rvalid_early: got %b want 0", a_c_rvalid); end
        @(negedge clk);
        vectors++; if (a_c_rvalid !== 1'b1) begin miscompares++; $display("FAIL rd1_rvalid: got %b want 1", a_c_rvalid); end
        vectors++; if (a_c_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd1_rdata: got %h want deadbeef", a_c_rdata); end
        vectors++; if (a_d_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd1_d_rvalid: got %b want 0", a_d_rvalid); end
        @(negedge clk);
        vectors++; if (a_c_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd1_rvalid_pulse: got %b want 0", a_c_rvalid); end
        repeat (4) @(negedge clk);
    endtask

    // Debug read to set d_rdata, then a debug write that must leave it alone.
    task automatic test_debug_write();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0030; mem_rdata = 32'hCAFE_F00D;
        #1;
        vectors++; if (a_d_gnt !== 1'b1) begin miscompares++; $display("FAIL wr_pre_gnt: got %b want 1", a_d_gnt); end
        @(negedge clk);
        d_req = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (a_d_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL wr_pre_rdata: got %h want cafef00d", a_d_rdata); end
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0020; d_wdata = 32'h1234_5678; d_be = 4'b0011;
        mem_rdata = 32'h5555_5555;
        #1;
        vectors++; if (a_d_gnt !== 1'b1) begin miscompares++; $display("FAIL wr_d_gnt: got %b want 1", a_d_gnt); end
        @(negedge clk);
        d_req = 1'b0;
        vectors++; if (a_mem_en !== 1'b1) begin miscompares++; $display("FAIL wr_mem_en: got %b want 1", a_mem_en); end
        vectors++; if (a_mem_we !== 1'b1) begin miscompares++; $display("FAIL wr_mem_we: got %b want 1", a_mem_we); end
        vectors++; if (a_mem_be !== 4'b0011) begin miscompares++; $display("FAIL wr_mem_be: got %b want 0011", a_mem_be); end
        vectors++; if (a_mem_addr !== 32'h0000_0020) begin miscompares++; $display("FAIL wr_mem_addr: got %h want 00000020", a_mem_addr); end
        vectors++; if (a_mem_wdata !== 32'h1234_5678) begin miscompares++; $display("FAIL wr_mem_wdata: got %h want 12345678", a_mem_wdata); end
        @(negedge clk);
        vectors++; if (a_mem_we !== 1'b0) begin miscompares++; $display("FAIL wr_mem_we_off: got %b want 0", a_mem_we); end
        vectors++; if (a_mem_be !== 4'b0000) begin miscompares++; $display("FAIL wr_mem_be_off: got %b want 0000", a_mem_be); end
        @(negedge clk);
        vectors++; if (a_d_rvalid !== 1'b1) begin miscompares++; $display("FAIL wr_d_rvalid: got %b want 1", a_d_rvalid); end
        vectors++; if (a_d_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL wr_d_rdata: got %h want cafef00d", a_d_rdata); end
        vectors++; if (a_c_rvalid !== 1'b0) begin miscompares++; $display("FAIL wr_c_rvalid: got %b want 0", a_c_rvalid); end
        repeat (6) @(negedge clk);
    endtask

    // MEM_LAT=3: mem_rdata changes every cycle; only the T+4 value is captured.
    task automatic test_read_lat3();
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0044; mem_rdata = 32'hA000_0000;
        #1;
        vectors++; if (b_c_gnt !== 1'b1) begin miscompares++; $display("FAIL rd3_c_gnt: got %b want 1", b_c_gnt); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) c_req = 1'b0;
            vectors++; if (b_mem_en !== (k == 1)) begin miscompares++; $display("FAIL rd3_mem_en[%0d]: got %b want %b", k, b_mem_en, k == 1); end
            vectors++; if (b_c_rvalid !== (k == 5)) begin miscompares++; $display("FAIL rd3_rvalid[%0d]: got %b want %b", k, b_c_rvalid, k == 5); end
            vectors++; if (a_c_rvalid !== (k == 3)) begin miscompares++; $display("FAIL rd3_lat1_rvalid[%0d]: got %b want %b", k, a_c_rvalid, k == 3); end
            if (k == 5) begin
                vectors++; if (b_c_rdata !== 32'hA000_0004) begin miscompares++; $display("FAIL rd3_rdata: got %h want a0000004", b_c_rdata); end
                vectors++; if (a_c_rdata !== 32'hA000_0002) begin miscompares++; $display("FAIL rd3_lat1_rdata: got %h want a0000002", a_c_rdata); end
            end
            mem_rdata = 32'hA000_0000 + 32'(k);
        end
    endtask

    // Reset during WAIT discards the access; afterwards the core wins a tie.
    task automatic test_reset_in_wait();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0050; mem_rdata = 32'h7777_7777;
        #1;
        vectors++; if (a_c_gnt !== 1'b1) begin miscompares++; $display("FAIL rw_c_gnt: got %b want 1", a_c_gnt); end
        @(negedge clk);
        c_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if (a_mem_en !== 1'b0) begin miscompares++; $display("FAIL rw_mem_en: got %b want 0", a_mem_en); end
        vectors++; if (a_c_rdata !== 32'h0) begin miscompares++; $display("FAIL rw_a_rdata: got %h want 0", a_c_rdata); end
        vectors++; if (b_c_rdata !== 32'h0) begin miscompares++; $display("FAIL rw_b_rdata: got %h want 0", b_c_rdata); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) reset = 1'b0;
            vectors++; if (a_c_rvalid !== 1'b0) begin miscompares++; $display("FAIL rw_no_rvalid[%0d]: got %b want 0", k, a_c_rvalid); end
            vectors++; if (a_mem_en !== 1'b0) begin miscompares++; $display("FAIL rw_no_mem_en[%0d]: got %b want 0", k, a_mem_en); end
        end
        c_req = 1'b1; d_req = 1'b1;
        #1;
        vectors++; if (a_c_gnt !== 1'b1) begin miscompares++; $display("FAIL rw_tie_c_gnt: got %b want 1", a_c_gnt); end
        vectors++; if (a_d_gnt !== 1'b0) begin miscompares++; $display("FAIL rw_tie_d_gnt: got %b want 0", a_d_gnt); end
        @(negedge clk);
        clear_inputs();
        repeat (10) @(negedge clk);
    endtask

    // One-cycle core request while D is being served: ignored, no access.
    task automatic test_drop_req();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0060; mem_rdata = 32'h600D_D00D;
        #1;
        vectors++; if (a_d_gnt !== 1'b1) begin miscompares++; $display("FAIL dr_d_gnt: got %b want 1", a_d_gnt); end
        @(negedge clk);
        d_req = 1'b0; c_req = 1'b1; c_addr = 32'h0000_0070;
        #1;
        vectors++; if (a_c_gnt !== 1'b0) begin miscompares++; $display("FAIL dr_c_gnt_t1: got %b want 0", a_c_gnt); end
        vectors++; if (a_mem_addr !== 32'h0000_0060) begin miscompares++; $display("FAIL dr_mem_addr: got %h want 00000060", a_mem_addr); end
        @(negedge clk);
        vectors++; if (a_c_gnt !== 1'b0) begin miscompares++; $display("FAIL dr_c_gnt_t2: got %b want 0", a_c_gnt); end
        c_req = 1'b0;
        @(negedge clk);
        vectors++; if (a_d_rvalid !== 1'b1) begin miscompares++; $display("FAIL dr_d_rvalid: got %b want 1", a_d_rvalid); end
        vectors++; if (a_d_rdata !== 32'h600D_D00D) begin miscompares++; $display("FAIL dr_d_rdata: got %h want 600dd00d", a_d_rdata); end
        vectors++; if (a_c_rvalid !== 1'b0) begin miscompares++; $display("FAIL dr_c_rvalid: got %b want 0", a_c_rvalid); end
        for (int k = 4; k <= 6; k++) begin
            @(negedge clk);
            vectors++; if (a_mem_en !== 1'b0) begin miscompares++; $display("FAIL dr_mem_en[%0d]: got %b want 0", k, a_mem_en); end
            vectors++; if (a_c_rvalid !== 1'b0) begin miscompares++; $display("FAIL dr_c_rvalid[%0d]: got %b want 0", k, a_c_rvalid); end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_alternate();
        test_read_lat1();
        test_debug_write();
        test_read_lat3();
        test_reset_in_wait();
        test_drop_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
